// File: rtl/if_id_skid_buffer_pkg.sv
// Shared IF/ID pipeline definitions: default datapath width, NOP encoding and entry layout.
package if_id_skid_buffer_pkg;

  localparam int unsigned IF_ID_WIDTH = 32;

  // Decode sees this word whenever the buffer is empty.
  localparam logic [IF_ID_WIDTH-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [IF_ID_WIDTH-1:0] pc;
    logic [IF_ID_WIDTH-1:0] instr;
  } if_id_entry_t;

endpackage : if_id_skid_buffer_pkg

// File: rtl/if_id_skid_buffer_sat_counter.sv
// Saturating up-counter; sticks at all-ones and clears only on reset.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt
);

  // Count enabled cycles, holding at the maximum value instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (en && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule : sat_counter

// File: rtl/if_id_skid_buffer.sv
// IF/ID pipeline buffer: small circular FIFO between fetch and decode with
// branch flush and a stall-cycle performance counter. in_ready is decoded from
// registered occupancy only, so decode stalls never reach fetch combinationally.
module if_id_skid_buffer
  import if_id_skid_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = IF_ID_WIDTH,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_pc,
  input  logic [WIDTH-1:0]         in_instr,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_pc,
  output logic [WIDTH-1:0]         out_instr,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  // Entries are held at the package width; WIDTH narrower than that is carried
  // in the low bits.
  if_id_entry_t       mem [DEPTH];
  if_id_entry_t       wr_entry;
  if_id_entry_t       head;
  logic [PTR_W-1:0]   wp;
  logic [PTR_W-1:0]   rp;
  logic               push;
  logic               pop;
  logic               stall_en;

  assign push     = in_valid & in_ready & ~flush;
  assign pop      = out_valid & out_ready & ~flush;
  assign stall_en = out_valid & ~out_ready & ~flush;

  // Pack the incoming fetch pair into the stored entry format.
  always_comb begin
    wr_entry       = '0;
    wr_entry.pc    = IF_ID_WIDTH'(in_pc);
    wr_entry.instr = IF_ID_WIDTH'(in_instr);
  end

  // Pointer and occupancy update; flush overrides any concurrent push or pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + PTR_W'(1);
      if (pop)  rp <= rp + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until marked valid by count.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wr_entry;
  end

  // Output decode from registered state; empty presents PC 0 and a NOP.
  always_comb begin
    head      = mem[rp];
    out_valid = (count != '0);
    in_ready  = (count < OCC_W'(DEPTH));
    out_pc    = '0;
    out_instr = WIDTH'(NOP_INSTR);
    if (out_valid) begin
      out_pc    = WIDTH'(head.pc);
      out_instr = WIDTH'(head.instr);
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (stall_en),
    .cnt (stall_cnt)
  );

endmodule : if_id_skid_buffer

// File: tb/tb_if_id_skid_buffer.sv
// Directed bench for if_id_skid_buffer with a queue-based scoreboard and an
// independent monitor that checks every decode-side handshake.
module tb_if_id_skid_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  logic [1:0]  count;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_instr_q[$];

  always #5 clk = ~clk;

  if_id_skid_buffer #(.WIDTH(32), .DEPTH(2), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_ready (out_ready),
    .count     (count),
    .stall_cnt (stall_cnt)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pair(input logic [31:0] pc, input logic [31:0] instr);
    exp_pc_q.push_back(pc);
    exp_instr_q.push_back(instr);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
    in_valid = v;
    in_pc    = pc;
    in_instr = instr;
  endtask

  // Monitor: at the falling edge, a visible handshake means the head is consumed next edge.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready && !flush) begin
      if (exp_pc_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got pc %0h instr %0h expected none", out_pc, out_instr);
      end else begin
        check("pop_pc", 64'(out_pc), 64'(exp_pc_q.pop_front()));
        check("pop_instr", 64'(out_instr), 64'(exp_instr_q.pop_front()));
      end
    end
  end

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #2;
    // Reset values while held in reset.
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_pc", 64'(out_pc), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Streaming with decode always ready: occupancy stays at 1.
    out_ready = 1'b1;
    expect_pair(32'h0, 32'h0000_0093);
    expect_pair(32'h4, 32'h0010_0113);
    expect_pair(32'h8, 32'h0020_0193);
    drive(1'b1, 32'h0, 32'h0000_0093);
    tick();
    check("stream_lat_pc0", 64'(out_pc), 64'h0);
    check("stream_count0", 64'(count), 64'd1);
    drive(1'b1, 32'h4, 32'h0010_0113);
    tick();
    check("stream_lat_pc4", 64'(out_pc), 64'h4);
    check("stream_count1", 64'(count), 64'd1);
    drive(1'b1, 32'h8, 32'h0020_0193);
    tick();
    check("stream_lat_pc8", 64'(out_pc), 64'h8);
    check("stream_count2", 64'(count), 64'd1);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("stream_drained", 64'(count), 64'd0);
    check("stream_no_stall", 64'(stall_cnt), 64'd0);

    // Decode stall: fill to 2, hold head, count stalled cycles.
    out_ready = 1'b0;
    expect_pair(32'h0, 32'h1111_0000);
    expect_pair(32'h4, 32'h2222_0004);
    drive(1'b1, 32'h0, 32'h1111_0000);
    tick();
    drive(1'b1, 32'h4, 32'h2222_0004);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check("stall_count_full", 64'(count), 64'd2);
    check("stall_in_ready_low", 64'(in_ready), 64'd0);
    check("stall_head_pc", 64'(out_pc), 64'h0);
    check("stall_cnt_1", 64'(stall_cnt), 64'd1);
    tick();
    tick();
    check("stall_cnt_3", 64'(stall_cnt), 64'd3);
    out_ready = 1'b1;
    tick();
    check("stall_pop_next_pc", 64'(out_pc), 64'h4);
    check("stall_pop_count", 64'(count), 64'd1);
    tick();
    check("stall_drained", 64'(count), 64'd0);

    // Full buffer with both sides active: drain one before accepting.
    out_ready = 1'b0;
    expect_pair(32'h100, 32'hA000_0100);
    expect_pair(32'h104, 32'hA000_0104);
    expect_pair(32'h108, 32'hA000_0108);
    drive(1'b1, 32'h100, 32'hA000_0100);
    tick();
    drive(1'b1, 32'h104, 32'hA000_0104);
    tick();
    check("full_stall_cnt", 64'(stall_cnt), 64'd4);
    out_ready = 1'b1;
    drive(1'b1, 32'h108, 32'hA000_0108);
    tick();
    check("full_after_pop_count", 64'(count), 64'd1);
    check("full_in_ready_back", 64'(in_ready), 64'd1);
    check("full_head_pc", 64'(out_pc), 64'h104);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check("full_pushpop_count", 64'(count), 64'd1);
    check("full_new_head", 64'(out_pc), 64'h108);
    tick();
    check("full_drained", 64'(count), 64'd0);

    // Flush while full with a concurrent fetch: everything is discarded.
    out_ready = 1'b0;
    drive(1'b1, 32'h200, 32'hB000_0200);
    tick();
    drive(1'b1, 32'h204, 32'hB000_0204);
    tick();
    check("flush_pre_count", 64'(count), 64'd2);
    flush = 1'b1;
    drive(1'b1, 32'h208, 32'hB000_0208);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("flush_count", 64'(count), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_out_instr", 64'(out_instr), 64'd0);
    check("flush_out_pc", 64'(out_pc), 64'd0);
    check("flush_no_stall", 64'(stall_cnt), 64'd5);
    // Flush at count 1 with room: the concurrent push and pop are both dropped.
    drive(1'b1, 32'h300, 32'hC000_0300);
    tick();
    flush = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'h304, 32'hC000_0304);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("flush1_count", 64'(count), 64'd0);
    expect_pair(32'h310, 32'hC000_0310);
    drive(1'b1, 32'h310, 32'hC000_0310);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check("post_flush_pc", 64'(out_pc), 64'h310);
    tick();
    check("post_flush_drained", 64'(count), 64'd0);

    // Asynchronous reset mid-stream with one entry buffered.
    out_ready = 1'b0;
    drive(1'b1, 32'h400, 32'hD000_0400);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check("mid_pre_count", 64'(count), 64'd1);
    rst = 1'b0;
    #1;
    check("async_count", 64'(count), 64'd0);
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("async_out_pc", 64'(out_pc), 64'd0);
    check("async_out_instr", 64'(out_instr), 64'd0);
    check("async_in_ready", 64'(in_ready), 64'd1);
    check("async_stall_cnt", 64'(stall_cnt), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    out_ready = 1'b1;
    expect_pair(32'h40, 32'hE000_0040);
    drive(1'b1, 32'h40, 32'hE000_0040);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_pc", 64'(out_pc), 64'h40);
    tick();
    check("post_rst_drained", 64'(count), 64'd0);

    // Saturation of the stall counter.
    out_ready = 1'b0;
    expect_pair(32'h500, 32'hF000_0500);
    drive(1'b1, 32'h500, 32'hF000_0500);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    for (int i = 0; i < (1 << 16) + 5; i++) tick();
    check("stall_saturated", 64'(stall_cnt), 64'hFFFF);
    out_ready = 1'b1;
    tick();
    check("sat_drained", 64'(count), 64'd0);
    check("sat_held", 64'(stall_cnt), 64'hFFFF);
    tick();
    check("scoreboard_empty", 64'(exp_pc_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_if_id_skid_buffer
